// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: PHT of 2-bit saturating counters indexed by PC xor global history.
// A sweep after reset fills every counter before predictions and training are enabled.
//
// state | meaning
// INIT  | sweeping INIT_COUNTER into PHT[init_ptr]; predictions forced not-taken, updates dropped
// RUN   | ready; predicting and training on resolved branches
module branch_predictor_gshare #(
  parameter int         PHT_INDEX_BITS = 10,
  parameter int         GHR_BITS       = 8,
  parameter logic [1:0] INIT_COUNTER   = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pred_valid,
  input  logic [31:0]               pred_pc,
  output logic                      pred_taken,
  output logic [PHT_INDEX_BITS-1:0] pred_index,
  input  logic                      upd_valid,
  input  logic [PHT_INDEX_BITS-1:0] upd_index,
  input  logic                      upd_outcome,
  input  logic                      upd_mispredict,
  output logic                      ready,
  output logic [31:0]               stat_predictions,
  output logic [31:0]               stat_mispredicts
);

  localparam int PHT_SIZE = 1 << PHT_INDEX_BITS;

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t                    state, state_next;
  logic [PHT_INDEX_BITS-1:0] init_ptr;
  logic [GHR_BITS-1:0]       ghr;
  logic [1:0]                pht [PHT_SIZE];
  logic [PHT_INDEX_BITS-1:0] ghr_ext;
  logic [1:0]                upd_cur, upd_next;
  logic                      upd_en;
  logic                      unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[31:PHT_INDEX_BITS+2], pred_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      INIT: if (init_ptr == PHT_INDEX_BITS'(PHT_SIZE - 1)) state_next = RUN;
      RUN:  ready = 1'b1;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                init_ptr <= '0;
    else if (state == INIT) init_ptr <= init_ptr + PHT_INDEX_BITS'(1);
  end

  assign ghr_ext    = PHT_INDEX_BITS'(ghr);
  assign pred_index = pred_pc[PHT_INDEX_BITS+1:2] ^ ghr_ext;
  assign pred_taken = ready & pht[pred_index][1];

  // Training is gated by ready so it can never collide with the sweep write.
  assign upd_en  = upd_valid & ready;
  assign upd_cur = pht[upd_index];

  always_comb begin
    upd_next = upd_cur;
    if (upd_outcome) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) pht[init_ptr]  <= INIT_COUNTER;
      else if (upd_en)   pht[upd_index] <= upd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ghr <= '0;
    else if (upd_en) ghr <= {ghr[GHR_BITS-2:0], upd_outcome};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_predictions <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pred_valid & ready)      stat_predictions <= stat_predictions + 32'd1;
      if (upd_en & upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule
